handshake_arbiter: RTL and testbench
====================================

# handshake_arbiter

Round-robin arbiter and transaction sequencer that shares one `handshake` channel between `NREQ` requesters. The winning requester's word goes out on the outbound lane (`port1`), and the block waits for the matching inbound word (`port2`). It returns that word to the owner and only then re-arbitrates. It sits between several `source`-style producers and a single `drain`-style consumer, one outstanding transaction at a time.

## Interface
- `WIDTH`, 32, lane data width; matches the `handshake` `WIDTH`.
- `NREQ`, 4, number of requesters (≥2).
- `TIMEOUT`, 255, response wait limit in cycles (used only with the timeout feature).
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_data`  in  NREQ*WIDTH  request words; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  one-hot pulse: the request is accepted this cycle.
- `rsp_valid`  out  NREQ  one-hot pulse: the response goes to requester i.
- `rsp_data`  out  WIDTH  response word, shared; valid with `rsp_valid`.
- `rsp_err`  out  1  response is a timeout; valid with `rsp_valid`.
- `port1`  out  WIDTH  outbound lane (dir1 side).
- `port1_valid`  out  1  outbound word valid.
- `port1_ready`  in  1  consumer accepts the outbound word.
- `port2`  in  WIDTH  inbound response lane.
- `port2_valid`  in  1  inbound word valid.
- `busy`  out  1  a transaction is in flight (state ≠ IDLE).
- `grant_id`  out  $clog2(NREQ)  index of the current or last owner.

## Operation
- FSM states: IDLE, SEND, WAIT.
- **IDLE:**
  - If any `req_valid` is high, the winner is the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - `req_ready[winner]` is high combinationally in this cycle.
  - On the edge: latch `req_data[winner]`, set `grant_id` and `last` to the winner, go to SEND.
  - With no requests, stay in IDLE; `last` is unchanged.
- **SEND:** `port1_valid`=1 and `port1` = latched word. If `port1_ready` is high → WAIT. Data stays stable while stalled.
- **WAIT:**
  - On `port2_valid`, register `rsp_data`=`port2`, `rsp_err`=0 and `rsp_valid[grant_id]`=1 for exactly one cycle. Go to IDLE.
- `port2_valid` in IDLE or SEND is ignored and dropped.
- `req_ready` is never high outside IDLE. Requesters hold `req_valid`/`req_data` until `req_ready`.
- Fairness: a requester that holds `req_valid` is granted within NREQ transactions.
- **Reset (including mid-transaction):**
  - Abandons the transaction; no response is issued.
  - State → IDLE; `last` → NREQ-1, so requester 0 wins first.
  - `grant_id`, `port1`, `rsp_data` → 0.
  - `port1_valid`, `rsp_valid`, `rsp_err`, `busy`, `req_ready` → 0.

## Timing
- Request accepted at cycle T → `port1_valid` from T+1.
- `port1_ready` at T+1 → WAIT from T+2.
- `port2_valid` at cycle W → `rsp_valid` at W+1; state is IDLE at W+1, and the next grant may happen at W+1.
- Minimum cost is 3 cycles per transaction.
- `rsp_valid`, `rsp_data`, `rsp_err`, `port1`, `port1_valid` and `grant_id` are registered.
- `req_ready` is combinational from state and `req_valid`.

## Configuration
- Macro: `HANDSHAKE_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8..32-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `port2_valid`, issue `rsp_valid[grant_id]`=1 with `rsp_err`=1 and `rsp_data`=0, and go to IDLE.
  - If `port2_valid` arrives in the same cycle the counter reaches `TIMEOUT`, the normal response wins.
- **Undefined:** no counter is built, WAIT lasts indefinitely, `rsp_err` is tied to 0 and `TIMEOUT` is unused.

## Structure
- `handshake_arb_pkg`:
  - state enum (IDLE/SEND/WAIT)
  - `ID_W` = $clog2(NREQ) helper function
  - timeout counter width constant
- Sub-module `rr_arbiter`: combinational rotate-priority picker. Inputs are the request vector and `last`; output is the one-hot grant plus index. It has no internal state; the arbiter top owns `last`.

## Test plan
- **Single request:** reset, `req_valid`=0001 with data 0xA5A5_0001 → `req_ready`=0001 at T; `port1`=0xA5A5_0001 with `port1_valid` at T+1. `port2`=0x1234 at W → `rsp_valid`=0001, `rsp_data`=0x1234 at W+1.
- **Round-robin:** all four requesters held valid, `port1_ready`=1, `port2_valid` one cycle after SEND → grant order 0,1,2,3,0; a new grant every 3 cycles.
- **Backpressure:** `port1_ready` low for 5 cycles in SEND → `port1`/`port1_valid` stable; WAIT is entered only after `port1_ready`.
- **Stray response:** `port2_valid` pulses in IDLE and SEND → no `rsp_valid`; the later real response is the one delivered.
- **Reset mid-WAIT:** `rst` for 1 cycle → all outputs 0 the next cycle, no response. With requesters 2 and 0 both valid, the next grant goes to requester 0.
- **Timeout (macro defined, `TIMEOUT`=8):** no `port2_valid` → `rsp_valid[owner]` with `rsp_err`=1 and `rsp_data`=0 after 8 WAIT cycles. Repeat with `port2_valid` exactly on cycle 8 → `rsp_err`=0 and the `port2` data is returned.

Source files
------------

// File: rtl/handshake_arb_pkg.sv
// -----------------------------------------------------------------------------
// handshake_arb_pkg
// Shared types and helpers for the handshake arbiter slice.
//   state_t      : transaction sequencer states (IDLE / SEND / WAIT)
//   id_w()       : width of a requester index for a given requester count
//   tmo_cnt_w()  : width of the response wait counter, clamped to 8..32 bits
// Optional feature macro used by this slice: HANDSHAKE_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package handshake_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int TMO_CNT_W_MIN = 8;
   localparam int TMO_CNT_W_MAX = 32;

   function automatic int id_w(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Wide enough to hold TIMEOUT, never narrower than 8 or wider than 32 bits.
   function automatic int tmo_cnt_w(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      if (w < TMO_CNT_W_MIN) w = TMO_CNT_W_MIN;
      if (w > TMO_CNT_W_MAX) w = TMO_CNT_W_MAX;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Stateless rotate-priority picker. The search starts at i_last+1 and wraps
// modulo NREQ; the first requesting index wins. The caller owns i_last.
// Ports:
//   i_req      in  NREQ  request vector
//   i_last     in  ID_W  index of the previous winner
//   o_grant    out NREQ  one-hot grant (all zero when no request)
//   o_grant_id out ID_W  index of the winner
//   o_any      out 1     at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
   import handshake_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = id_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [ID_W-1:0] i_last,
   output logic [NREQ-1:0] o_grant,
   output logic [ID_W-1:0] o_grant_id,
   output logic            o_any
);

   function automatic int wrap_idx(input int base, input int offset);
      return (base + offset) % NREQ;
   endfunction

   always_comb begin
      // NOTE: every output gets a default before the search so no path
      // leaves a value unassigned, which would otherwise infer a latch.
      o_grant    = '0;
      o_grant_id = '0;
      o_any      = 1'b0;
      // Offset 1 first, offset NREQ (the last winner itself) last.
      for (int k = 1; k <= NREQ; k++) begin
         if (!o_any && i_req[wrap_idx(int'(i_last), k)]) begin
            o_any                            = 1'b1;
            o_grant[wrap_idx(int'(i_last), k)] = 1'b1;
            o_grant_id                       = ID_W'(wrap_idx(int'(i_last), k));
         end
      end
   end

endmodule

// File: rtl/handshake_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_arbiter
// Round-robin arbiter and transaction sequencer sharing one handshake channel
// between NREQ requesters, one outstanding transaction at a time. The winner's
// word goes out on port1; the matching port2 word is returned to the owner,
// and only then does the block re-arbitrate.
// Optional feature: define HANDSHAKE_ARB_TIMEOUT_EN to build a response wait
// counter that answers with rsp_err=1 after TIMEOUT WAIT cycles.
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   req_valid/req_data  per-requester request and word (i at [i*WIDTH +: WIDTH])
//   req_ready           one-hot, combinational: request accepted this cycle
//   rsp_valid           one-hot pulse: response goes to requester i
//   rsp_data, rsp_err   response word / timeout flag, valid with rsp_valid
//   port1, port1_valid, port1_ready   outbound lane
//   port2, port2_valid                inbound response lane
//   busy                a transaction is in flight
//   grant_id            index of the current or last owner
// -----------------------------------------------------------------------------
module handshake_arbiter
   import handshake_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err,
   output logic [WIDTH-1:0]        port1,
   output logic                    port1_valid,
   input  logic                    port1_ready,
   input  logic [WIDTH-1:0]        port2,
   input  logic                    port2_valid,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int ID_W = $clog2(NREQ);

   state_t            r_state;
   state_t            w_state_next;
   logic [ID_W-1:0]   r_last;
   logic [ID_W-1:0]   r_grant_id;
   logic [WIDTH-1:0]  r_port1;
   logic              r_port1_valid;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [WIDTH-1:0]  r_rsp_data;

   logic [NREQ-1:0]   w_grant;
   logic [ID_W-1:0]   w_win_id;
   logic              w_any;
   logic [WIDTH-1:0]  w_req_word;
   logic [NREQ-1:0]   w_owner_onehot;
   logic              w_timeout;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .i_req      (req_valid),
      .i_last     (r_last),
      .o_grant    (w_grant),
      .o_grant_id (w_win_id),
      .o_any      (w_any)
   );

   assign w_req_word     = req_data[w_win_id*WIDTH +: WIDTH];
   assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;

   // ---------------------------------------------------------------------------
   // Optional response timeout
   // ---------------------------------------------------------------------------
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
   localparam int TMO_CNT_W = tmo_cnt_w(TIMEOUT);

   logic [TMO_CNT_W-1:0] r_wait_cnt;
   logic [TMO_CNT_W-1:0] w_cnt_next;
   logic                 r_rsp_err;

   // The counter holds k-1 during the k-th WAIT cycle, so the k-th cycle is
   // the one where it "reaches" k; a port2 word in that same cycle wins.
   assign w_cnt_next = r_wait_cnt + 1'b1;
   assign w_timeout  = (r_state == WAIT) && (w_cnt_next == TMO_CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == SEND && port1_ready) begin
         r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_wait_cnt <= w_cnt_next;
      end
   end

   assign rsp_err = r_rsp_err;
`else
   // TIMEOUT only matters in the timeout build.
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = TIMEOUT;
   assign w_timeout        = 1'b0;
   assign rsp_err          = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of block order.
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = '0;
      case (r_state)
         // Gated by rst so a requester never sees an acceptance that the
         // reset edge is about to discard.
         IDLE: if (w_any && !rst) begin
            req_ready    = w_grant;
            w_state_next = SEND;
         end
         SEND: if (port1_ready) w_state_next = WAIT;
         WAIT: if (port2_valid || w_timeout) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered datapath and outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last        <= ID_W'(NREQ - 1);
         r_grant_id    <= '0;
         r_port1       <= '0;
         r_port1_valid <= 1'b0;
         r_rsp_valid   <= '0;
         r_rsp_data    <= '0;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
         r_rsp_err     <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: if (w_any) begin
               r_port1       <= w_req_word;
               r_grant_id    <= w_win_id;
               r_last        <= w_win_id;
               r_port1_valid <= 1'b1;
            end
            SEND: if (port1_ready) r_port1_valid <= 1'b0;
            WAIT: begin
               if (port2_valid) begin
                  r_rsp_valid <= w_owner_onehot;
                  r_rsp_data  <= port2;
`ifdef HANDSHAKE_ARB_TIMEOUT_EN
                  r_rsp_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp_valid <= w_owner_onehot;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign grant_id    = r_grant_id;
   assign port1       = r_port1;
   assign port1_valid = r_port1_valid;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_arbiter
// Directed self-checking bench for handshake_arbiter (WIDTH=32, NREQ=4,
// TIMEOUT=8). Inputs change 1 time unit after the rising edge; outputs are
// compared 1 time unit later, away from the edge. Timeout cases are built
// only when HANDSHAKE_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_handshake_arbiter;

   localparam int WIDTH   = 32;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic [WIDTH-1:0]      port1;
   logic                  port1_valid;
   logic                  port1_ready;
   logic [WIDTH-1:0]      port2;
   logic                  port2_valid;
   logic                  busy;
   logic [1:0]            grant_id;

   int n_tests = 0;
   int n_fail  = 0;
   int id;

   always #5 clk = ~clk;

   handshake_arbiter #(
      .WIDTH   (WIDTH),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .port1       (port1),
      .port1_valid (port1_valid),
      .port1_ready (port1_ready),
      .port2       (port2),
      .port2_valid (port2_valid),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid   = '0;
      port1_ready = 1'b0;
      port2_valid = 1'b0;
      port2       = '0;
   endtask

   task automatic set_word(input int i, input logic [31:0] w);
      req_data[i*WIDTH +: WIDTH] = w;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      req_data = '0;
      idle_inputs();
      tick();
      tick();

      // ---------------- Reset state ----------------
      #1;
      check("rst_busy",        busy,        0);
      check("rst_port1_valid", port1_valid, 0);
      check("rst_rsp_valid",   rsp_valid,   0);
      check("rst_grant_id",    grant_id,    0);
      check("rst_port1",       port1,       0);
      check("rst_rsp_data",    rsp_data,    0);
      check("rst_rsp_err",     rsp_err,     0);
      check("rst_req_ready",   req_ready,   0);
      rst = 1'b0;

      // ---------------- Single request ----------------
      req_valid = 4'b0001;
      set_word(0, 32'hA5A5_0001);
      #1;
      check("single_req_ready_T", req_ready, 4'b0001);
      tick();
      check("single_port1_valid", port1_valid, 1);
      check("single_port1",       port1,       32'hA5A5_0001);
      check("single_grant_id",    grant_id,    0);
      check("single_busy",        busy,        1);
      check("single_no_ready_send", req_ready, 0);
      req_valid   = '0;
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      check("single_wait_port1_valid", port1_valid, 0);
      port2       = 32'h0000_1234;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("single_rsp_valid", rsp_valid, 4'b0001);
      check("single_rsp_data",  rsp_data,  32'h0000_1234);
      check("single_rsp_err",   rsp_err,   0);
      check("single_idle",      busy,      0);
      tick();
      check("single_rsp_pulse", rsp_valid, 0);

      // ---------------- Round-robin ----------------
      do_reset();
      for (int i = 0; i < NREQ; i++) set_word(i, 32'hC0DE_0000 + i);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         id = k % NREQ;
         #1;
         check("rr_req_ready", req_ready, 64'(1) << id);
         tick();
         check("rr_grant_id", grant_id, id);
         check("rr_port1",    port1,    32'hC0DE_0000 + id);
         port1_ready = 1'b1;
         tick();
         port1_ready = 1'b0;
         port2       = 32'h5000 + k;
         port2_valid = 1'b1;
         tick();
         port2_valid = 1'b0;
         check("rr_rsp_valid", rsp_valid, 64'(1) << id);
         check("rr_rsp_data",  rsp_data,  32'h5000 + k);
      end
      req_valid = '0;

      // ---------------- Stray response in IDLE ----------------
      do_reset();
      port2       = 32'hDEAD_0001;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("stray_idle_rsp_valid", rsp_valid, 0);
      check("stray_idle_busy",      busy,      0);

      // ---------------- Backpressure ----------------
      set_word(2, 32'hBEEF_0002);
      req_valid = 4'b0100;
      #1;
      check("bp_req_ready", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0001;
      set_word(0, 32'h0000_0A0A);
      for (int s = 0; s < 5; s++) begin
         #1;
         check("bp_port1_valid", port1_valid, 1);
         check("bp_port1",       port1,       32'hBEEF_0002);
         check("bp_no_ready",    req_ready,   0);
         tick();
      end
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      check("bp_wait_port1_valid", port1_valid, 0);
      check("bp_wait_busy",        busy,        1);
      port2       = 32'h0000_0B0B;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("bp_rsp_valid", rsp_valid, 4'b0100);
      check("bp_rsp_data",  rsp_data,  32'h0000_0B0B);

      // ---------------- Stray response in SEND ----------------
      #1;
      check("stray_send_req_ready", req_ready, 4'b0001);
      tick();
      req_valid   = '0;
      port2       = 32'hDEAD_0002;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("stray_send_rsp_valid",   rsp_valid,   0);
      check("stray_send_port1_valid", port1_valid, 1);
      check("stray_send_port1",       port1,       32'h0000_0A0A);
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      port2       = 32'h0000_600D;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("stray_real_rsp_valid", rsp_valid, 4'b0001);
      check("stray_real_rsp_data",  rsp_data,  32'h0000_600D);

      // ---------------- Reset mid-WAIT ----------------
      set_word(3, 32'h3333_0003);
      req_valid = 4'b1000;
      #1;
      check("rstw_req_ready", req_ready, 4'b1000);
      tick();
      req_valid   = '0;
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      check("rstw_busy_wait", busy,     1);
      check("rstw_grant_id3", grant_id, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_word(0, 32'h0000_AAAA);
      set_word(2, 32'h0000_2222);
      req_valid = 4'b0101;
      #1;
      check("rstw_busy",        busy,        0);
      check("rstw_port1_valid", port1_valid, 0);
      check("rstw_port1",       port1,       0);
      check("rstw_rsp_valid",   rsp_valid,   0);
      check("rstw_rsp_data",    rsp_data,    0);
      check("rstw_grant_id",    grant_id,    0);
      check("rstw_rsp_err",     rsp_err,     0);
      check("rstw_req_ready",   req_ready,   4'b0001);
      tick();
      req_valid = '0;
      check("rstw_next_grant", grant_id,  0);
      check("rstw_next_port1", port1,     32'h0000_AAAA);
      check("rstw_no_rsp",     rsp_valid, 0);

`ifdef HANDSHAKE_ARB_TIMEOUT_EN
      // ---------------- Timeout: no response ----------------
      do_reset();
      set_word(1, 32'h1111_0001);
      req_valid = 4'b0010;
      #1;
      check("tmo_req_ready", req_ready, 4'b0010);
      tick();
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      for (int c = 1; c <= TIMEOUT; c++) begin
         check("tmo_no_rsp_yet", rsp_valid, 0);
         check("tmo_busy",       busy,      1);
         tick();
      end
      check("tmo_rsp_valid", rsp_valid, 4'b0010);
      check("tmo_rsp_err",   rsp_err,   1);
      check("tmo_rsp_data",  rsp_data,  0);
      check("tmo_idle",      busy,      0);

      // ---------------- Timeout: response on the last cycle ----------------
      #1;
      check("tmo2_req_ready", req_ready, 4'b0010);
      tick();
      req_valid   = '0;
      port1_ready = 1'b1;
      tick();
      port1_ready = 1'b0;
      for (int c = 1; c < TIMEOUT; c++) tick();
      port2       = 32'h0000_0077;
      port2_valid = 1'b1;
      tick();
      port2_valid = 1'b0;
      check("tmo2_rsp_valid", rsp_valid, 4'b0010);
      check("tmo2_rsp_err",   rsp_err,   0);
      check("tmo2_rsp_data",  rsp_data,  32'h0000_0077);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
